nn_mem_sched: RTL and testbench

- Sequential, fair scheduler that shares the single coefficient-memory (cmem) and data-memory (dmem) address port between NUM_REQ NN engines (index 0 = rcal, 1 = fp, others spare).
- Replaces fixed-priority combinational selection with round-robin ownership, hold-while-requested, bounded tenure with preemption, and registered address outputs.
- Sits between the NN engines and the cmem/dmem banks.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/nn_rr_pick.sv | 39 +++
 rtl/nn_mem_sched.sv | 179 +++++++++++++++++
 tb/tb_nn_mem_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// ============================================================================
// Module : nn_pkg
// Brief  : Shared NN memory types, scheduler defaults and scheduler state enum.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_pkg;

  typedef logic [7:0] Caddr;
  typedef logic [7:0] Maddr;

  localparam int NN_NUM_REQ  = 2;
  localparam int NN_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_SWITCH = 2'd2
  } nn_sched_state_e;

endpackage

`default_nettype wire

// File: rtl/nn_rr_pick.sv
// ============================================================================
// Module : nn_rr_pick
// Brief  : Combinational round-robin picker: first set request at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_rr_pick
  import nn_pkg::*;
#(
  parameter int NUM_REQ = NN_NUM_REQ,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IDW-1:0]     win_idx_o
);

  int j;

  // Scan from the farthest offset down so the nearest request overwrites last.
  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    j         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[j]) begin
        win_o     = '0;
        win_o[j]  = 1'b1;
        win_idx_o = IDW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/nn_mem_sched.sv
// ============================================================================
// Module : nn_mem_sched
// Brief  : Round-robin cmem/dmem port scheduler with bounded tenure/preemption.
//          Optional perf counters enabled by macro NN_MEM_SCHED_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_mem_sched
  import nn_pkg::*;
#(
  parameter int NUM_REQ  = NN_NUM_REQ,
  parameter int MAX_HOLD = NN_MAX_HOLD,
  parameter int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  output logic [NUM_REQ-1:0]       grant,
  input  Caddr [NUM_REQ-1:0]       cmem_addr_req,
  input  Maddr [NUM_REQ-1:0]       dmem_addr_req,
  output Caddr                     cmem_addr,
  output Maddr                     dmem_addr,
  output logic                     busy,
  output logic [IDW-1:0]           owner_id,
  output logic                     preempt
`ifdef NN_MEM_SCHED_PERF_EN
  ,
  output logic [NUM_REQ-1:0][15:0] grant_cnt,
  output logic [15:0]              max_wait
`endif
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  nn_sched_state_e    state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [7:0]         hold_q, hold_d;
  Caddr               cmem_q, cmem_d;
  Maddr               dmem_q, dmem_d;
  logic               preempt_q, preempt_d;

  logic [NUM_REQ-1:0] win;
  logic [IDW-1:0]     win_idx;
  logic [7:0]         hold_inc;
  logic               owner_req;
  logic               others_req;
  logic               tenure_up;
  logic [IDW-1:0]     owner_nxt;

  nn_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  assign owner_req  = req[owner_q];
  assign others_req = |(req & ~grant_q);
  assign hold_inc   = (hold_q == HOLD_MAX) ? hold_q : hold_q + 8'd1;
  // Tenure is judged on the count including the current BUSY cycle.
  assign tenure_up  = (hold_inc == HOLD_MAX) && others_req;
  assign owner_nxt  = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      cmem_q    <= '0;
      dmem_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      cmem_q    <= cmem_d;
      dmem_q    <= dmem_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_SWITCH: state_d = (|req) ? ST_BUSY : ST_IDLE;
      ST_BUSY:            if (!owner_req || tenure_up) state_d = ST_SWITCH;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    cmem_d    = cmem_q;
    dmem_d    = dmem_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_SWITCH: begin
        grant_d = win;
        if (|req) begin
          owner_d = win_idx;
          hold_d  = '0;
          cmem_d  = cmem_addr_req[win_idx];
          dmem_d  = dmem_addr_req[win_idx];
        end
      end
      ST_BUSY: begin
        cmem_d = cmem_addr_req[owner_q];
        dmem_d = dmem_addr_req[owner_q];
        hold_d = hold_inc;
        if (!owner_req || tenure_up) begin
          grant_d   = '0;
          ptr_d     = owner_nxt;
          preempt_d = owner_req;
        end
      end
      default: grant_d = '0;
    endcase
  end

  assign grant     = grant_q;
  assign cmem_addr = cmem_q;
  assign dmem_addr = dmem_q;
  assign busy      = (state_q == ST_BUSY);
  assign owner_id  = owner_q;
  assign preempt   = preempt_q;

`ifdef NN_MEM_SCHED_PERF_EN
  logic [NUM_REQ-1:0]       new_grant;
  logic [NUM_REQ-1:0][15:0] gcnt_q;
  logic [NUM_REQ-1:0][15:0] wait_q;
  logic [15:0]              max_wait_q;

  assign new_grant = (state_q != ST_BUSY) ? win : '0;

  // A request granted on the edge it is first seen counts as one cycle of delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q     <= '0;
      wait_q     <= '0;
      max_wait_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (new_grant[i]) begin
          gcnt_q[i] <= gcnt_q[i] + 16'd1;
          if (wait_q[i] != 16'hFFFF && wait_q[i] + 16'd1 > max_wait_q)
            max_wait_q <= wait_q[i] + 16'd1;
          else if (wait_q[i] == 16'hFFFF)
            max_wait_q <= 16'hFFFF;
        end
        if (req[i] && !grant_q[i] && !new_grant[i])
          wait_q[i] <= (wait_q[i] == 16'hFFFF) ? wait_q[i] : wait_q[i] + 16'd1;
        else
          wait_q[i] <= '0;
      end
    end
  end

  assign grant_cnt = gcnt_q;
  assign max_wait  = max_wait_q;
`endif

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule

`default_nettype wire

// File: tb/tb_nn_mem_sched.sv
// ============================================================================
// Module : tb_nn_mem_sched
// Brief  : Self-checking bench for nn_mem_sched against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nn_mem_sched;
  import nn_pkg::*;

  localparam int N   = 3;
  localparam int MH  = 4;
  localparam int IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req;
  logic [N-1:0]         grant;
  logic [N-1:0][7:0]    cmem_addr_req;
  logic [N-1:0][7:0]    dmem_addr_req;
  logic [7:0]           cmem_addr;
  logic [7:0]           dmem_addr;
  logic                 busy;
  logic [IDW-1:0]       owner_id;
  logic                 preempt;
`ifdef NN_MEM_SCHED_PERF_EN
  logic [N-1:0][15:0]   grant_cnt;
  logic [15:0]          max_wait;
`endif

  always #5 clk = ~clk;

  nn_mem_sched #(
    .NUM_REQ  (N),
    .MAX_HOLD (MH),
    .IDW      (IDW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .grant         (grant),
    .cmem_addr_req (cmem_addr_req),
    .dmem_addr_req (dmem_addr_req),
    .cmem_addr     (cmem_addr),
    .dmem_addr     (dmem_addr),
    .busy          (busy),
    .owner_id      (owner_id),
    .preempt       (preempt)
`ifdef NN_MEM_SCHED_PERF_EN
    ,
    .grant_cnt     (grant_cnt),
    .max_wait      (max_wait)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0 = idle, 1 = owned, 2 = dead cycle after a release.
  int           m_phase, m_owner, m_ptr, m_ten;
  logic [7:0]   m_cm, m_dm;
  logic         m_pre;
  logic [N-1:0] prev_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_ten = 0;
    m_cm = '0; m_dm = '0; m_pre = 1'b0;
  endtask

  task automatic model_step();
    int w;
    logic [N-1:0] others;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_pre = 1'b0;
    if (m_phase == 1) begin
      m_cm = cmem_addr_req[m_owner];
      m_dm = dmem_addr_req[m_owner];
      if (m_ten < MH) m_ten++;
      others = req;
      others[m_owner] = 1'b0;
      if (!req[m_owner]) begin
        m_phase = 2;
        m_ptr   = (m_owner + 1) % N;
      end else if (m_ten == MH && others != 0) begin
        m_phase = 2;
        m_pre   = 1'b1;
        m_ptr   = (m_owner + 1) % N;
      end
    end else begin
      w = rr_winner(req, m_ptr);
      if (w >= 0) begin
        m_phase = 1; m_owner = w; m_ten = 0;
        m_cm = cmem_addr_req[w];
        m_dm = dmem_addr_req[w];
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_grant;
    exp_grant = '0;
    if (m_phase == 1) exp_grant[m_owner] = 1'b1;
    chk("grant",     32'(grant),     32'(exp_grant));
    chk("busy",      32'(busy),      32'(m_phase == 1));
    chk("preempt",   32'(preempt),   32'(m_pre));
    chk("cmem_addr", 32'(cmem_addr), 32'(m_cm));
    chk("dmem_addr", 32'(dmem_addr), 32'(m_dm));
    if (m_phase == 1) chk("owner_id", 32'(owner_id), 32'(m_owner));
    chk("adjacent_grant", 32'(prev_grant != 0 && grant != 0 && prev_grant != grant), 32'd0);
    prev_grant = grant;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    cmem_addr_req = '0;
    dmem_addr_req = '0;
    prev_grant = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();

    // Single requester, address follows with one cycle of latency.
    cmem_addr_req[0] = 8'h11; dmem_addr_req[0] = 8'h5A; req = 3'b001; tick();
    cmem_addr_req[0] = 8'h22; tick();
    repeat (6) tick();
    req = '0; tick(); tick();

    // Contention with pointer already advanced past requester 0.
    cmem_addr_req[1] = 8'h33; dmem_addr_req[1] = 8'h44; req = 3'b011; tick();
    repeat (2) tick();
    req[1] = 1'b0; tick(); tick();
    repeat (2) tick();
    req = '0; tick(); tick();

    // Preemption: two requesters held for several tenures.
    req = 3'b001; tick();
    req = 3'b011; repeat (14) tick();
    req = '0; repeat (3) tick();

    // Single long holder: never preempted.
    req = 3'b100;
    repeat (40) begin
      cmem_addr_req[2] = 8'($urandom);
      dmem_addr_req[2] = 8'($urandom);
      tick();
    end
    req = '0; tick(); tick();

    // Randomized request toggling and addresses.
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
        cmem_addr_req[i] = 8'($urandom);
        dmem_addr_req[i] = 8'($urandom);
      end
      tick();
    end

    // Asynchronous reset mid-tenure.
    req = 3'b010; repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    cmem_addr_req[1] = 8'hA5; req = 3'b010; tick(); tick();
    req = '0; tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
